// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: receiver FSM state encoding,
// parity-mode constants and the parity helper used by the receiver.
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Widest word the receiver supports; narrower words are zero-extended
  // before being handed to word_parity().
  localparam int MAX_DATA_BITS = 9;

  // XOR reduction of a (zero-extended) data word: 1 when the word holds an
  // odd number of ones.
  function automatic logic word_parity(input logic [MAX_DATA_BITS-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// ---------------------------------------------------------------------------
// uart_sync
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk  - sampling clock
//   rst  - synchronous active-high reset, loads RESET_VAL into both flops
//   d    - asynchronous input
//   q    - synchronized output (two clocks of latency)
// ---------------------------------------------------------------------------
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_framed.sv
// ---------------------------------------------------------------------------
// uart_rx_framed
// UART receiver with configurable data width, optional even/odd parity,
// 1 or 2 stop bits, start-glitch filtering, framing/parity error flags,
// a ready/valid output register with overrun detection and a running sum
// of error-free words.
// Parameters:
//   cycles_per_bit (>=2), data_bits (5..9), parity_mode (0 none/1 even/2 odd),
//   stop_bits (1 or 2)
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   i_serial        - asynchronous serial line, idle high
//   o_data          - received word (LSB first on the wire)
//   o_valid/i_ready - output handshake
//   o_parity_err    - parity mismatch for the held word
//   o_frame_err     - a stop bit sampled low for the held word
//   o_overrun       - frames dropped since the last handshake
//   o_sum           - running sum of error-free words loaded
// ---------------------------------------------------------------------------
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int cycles_per_bit = 4,
  parameter int data_bits      = 8,
  parameter int parity_mode    = 0,
  parameter int stop_bits      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_serial,
  output logic [data_bits-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic [31:0]          o_sum
);

  localparam int CNT_W = $clog2(cycles_per_bit);
  localparam int IDX_W = $clog2(data_bits + 1);
  localparam int HALF  = cycles_per_bit / 2;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(cycles_per_bit - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(data_bits - 1);
  localparam logic             STOP_LAST  = 1'(stop_bits - 1);
  localparam logic             HAS_PARITY = (parity_mode != PARITY_NONE);
  localparam logic             ODD_SENSE  = (parity_mode == PARITY_ODD);

  logic                 line;
  rx_state_t            state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [data_bits-1:0] shreg, shreg_nxt;
  logic                 perr, perr_nxt;
  logic                 ferr, ferr_nxt;
  logic                 stop_idx, stop_idx_nxt;
  logic                 tick;
  logic                 done;
  logic                 handshake;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (i_serial),
    .q   (line)
  );

  assign tick      = (cnt == CNT_ZERO);
  assign handshake = o_valid & i_ready;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and frame datapath decode; done pulses on the final stop sample.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    idx_nxt      = idx;
    shreg_nxt    = shreg;
    perr_nxt     = perr;
    ferr_nxt     = ferr;
    stop_idx_nxt = stop_idx;
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (line == 1'b0) begin
          state_nxt = START;
          cnt_nxt   = CNT_HALF;
        end else begin
          cnt_nxt   = CNT_ZERO;
        end
      end
      START: begin
        if (tick) begin
          // A line back high at mid-start is treated as a glitch.
          if (line) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            cnt_nxt   = CNT_FULL;
            idx_nxt   = IDX_ZERO;
            perr_nxt  = 1'b0;
            ferr_nxt  = 1'b0;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      DATA: begin
        if (tick) begin
          // Right-shift insertion: first bit received lands in bit 0.
          shreg_nxt = {line, shreg[data_bits-1:1]};
          idx_nxt   = idx + IDX_ONE;
          cnt_nxt   = CNT_FULL;
          if (idx == IDX_LAST) begin
            stop_idx_nxt = 1'b0;
            if (HAS_PARITY) begin
              state_nxt = PARITY;
            end else begin
              state_nxt = STOP;
            end
          end else begin
            state_nxt = DATA;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      PARITY: begin
        if (tick) begin
          perr_nxt     = word_parity(MAX_DATA_BITS'(shreg)) ^ line ^ ODD_SENSE;
          cnt_nxt      = CNT_FULL;
          stop_idx_nxt = 1'b0;
          state_nxt    = STOP;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      STOP: begin
        if (tick) begin
          ferr_nxt = ferr | ~line;
          if (stop_idx == STOP_LAST) begin
            done    = 1'b1;
            cnt_nxt = CNT_ZERO;
            // A low final stop sample means a framing error with the line
            // still low: wait out the break before hunting for a start.
            if (line == 1'b0) begin
              state_nxt = BREAK;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            stop_idx_nxt = 1'b1;
            cnt_nxt      = CNT_FULL;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      BREAK: begin
        if (line) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = BREAK;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // Frame datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= CNT_ZERO;
      idx      <= IDX_ZERO;
      shreg    <= {data_bits{1'b0}};
      perr     <= 1'b0;
      ferr     <= 1'b0;
      stop_idx <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      shreg    <= shreg_nxt;
      perr     <= perr_nxt;
      ferr     <= ferr_nxt;
      stop_idx <= stop_idx_nxt;
    end
  end

  // Output register: load on completion when free (or freed this cycle),
  // otherwise drop the frame and flag overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_data       <= {data_bits{1'b0}};
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
      o_sum        <= 32'd0;
    end else if (done && (!o_valid || handshake)) begin
      o_data       <= shreg;
      o_valid      <= 1'b1;
      o_parity_err <= perr;
      o_frame_err  <= ferr_nxt;
      o_overrun    <= 1'b0;
      if (!perr && !ferr_nxt) begin
        o_sum <= o_sum + 32'(shreg);
      end else begin
        o_sum <= o_sum;
      end
    end else if (done) begin
      o_overrun <= 1'b1;
    end else if (handshake) begin
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_valid <= o_valid;
    end
  end

endmodule

// File: tb/tb_uart_rx_framed.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_framed
// Directed bench for uart_rx_framed. dut: 4 clk/bit, 8 data bits, even
// parity, 1 stop. dut7: 4 clk/bit, 7 data bits, no parity, 2 stops.
// ---------------------------------------------------------------------------
module tb_uart_rx_framed;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ser = 1'b1;
  logic        rdy = 1'b1;
  logic [7:0]  o_data;
  logic        o_valid, o_perr, o_ferr, o_ovr;
  logic [31:0] o_sum;

  logic        ser7 = 1'b1;
  logic        rdy7 = 1'b1;
  logic [6:0]  o_data7;
  logic        o_valid7, o_perr7, o_ferr7, o_ovr7;
  logic [31:0] o_sum7;

  int vectors     = 0;
  int miscompares = 0;

  // Handshake capture for dut
  int         cap_cnt = 0;
  int         vcycles = 0;
  logic [7:0] cap_data [4];
  logic       cap_perr [4];
  logic       cap_ferr [4];

  // Handshake capture for dut7
  int         cap7_cnt = 0;
  logic [6:0] cap7_data;
  logic       cap7_err;

  uart_rx_framed #(.cycles_per_bit(4), .data_bits(8), .parity_mode(1), .stop_bits(1)) dut (
    .clk(clk), .rst(rst), .i_serial(ser), .o_data(o_data), .o_valid(o_valid),
    .i_ready(rdy), .o_parity_err(o_perr), .o_frame_err(o_ferr),
    .o_overrun(o_ovr), .o_sum(o_sum)
  );

  uart_rx_framed #(.cycles_per_bit(4), .data_bits(7), .parity_mode(0), .stop_bits(2)) dut7 (
    .clk(clk), .rst(rst), .i_serial(ser7), .o_data(o_data7), .o_valid(o_valid7),
    .i_ready(rdy7), .o_parity_err(o_perr7), .o_frame_err(o_ferr7),
    .o_overrun(o_ovr7), .o_sum(o_sum7)
  );

  always #5 clk = ~clk;

  // Record every accepted word (values seen at the handshake edge).
  always @(posedge clk) begin
    if (rst) begin
      cap_cnt  <= 0;
      vcycles  <= 0;
      cap7_cnt <= 0;
    end else begin
      if (o_valid) vcycles <= vcycles + 1;
      if (o_valid && rdy) begin
        if (cap_cnt < 4) begin
          cap_data[cap_cnt] <= o_data;
          cap_perr[cap_cnt] <= o_perr;
          cap_ferr[cap_cnt] <= o_ferr;
        end
        cap_cnt <= cap_cnt + 1;
      end
      if (o_valid7 && rdy7) begin
        cap7_data <= o_data7;
        cap7_err  <= o_perr7 | o_ferr7;
        cap7_cnt  <= cap7_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; ser = 1'b1; ser7 = 1'b1; rdy = 1'b1; rdy7 = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) ser7 = v;
    else     ser  = v;
    idle(4);
  endtask

  // pbit < 0 means no parity bit is sent.
  task automatic send_frame(input bit sel, input logic [8:0] d, input int nd,
                            input int pbit, input logic stopv, input int nstop);
    drive(sel, 1'b0);
    for (int i = 0; i < nd; i++) drive(sel, d[i]);
    if (pbit >= 0) drive(sel, pbit[0]);
    for (int i = 0; i < nstop; i++) drive(sel, stopv);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_valid",   32'(o_valid), 32'd0);
    chk("rst_data",    32'(o_data),  32'd0);
    chk("rst_flags",   {29'd0, o_perr, o_ferr, o_ovr}, 32'd0);
    chk("rst_sum",     o_sum,        32'd0);

    // 1: clean 0x55, even parity bit 0
    send_frame(1'b0, 9'h055, 8, 0, 1'b1, 1);
    idle(10);
    chk("s1_count", 32'(cap_cnt),     32'd1);
    chk("s1_data",  32'(cap_data[0]), 32'h55);
    chk("s1_perr",  32'(cap_perr[0]), 32'd0);
    chk("s1_ferr",  32'(cap_ferr[0]), 32'd0);
    chk("s1_vcyc",  32'(vcycles),     32'd1);
    chk("s1_sum",   o_sum,            32'h55);

    // 2: 0x55 with wrong parity bit
    do_reset();
    send_frame(1'b0, 9'h055, 8, 1, 1'b1, 1);
    idle(10);
    chk("s2_count", 32'(cap_cnt),     32'd1);
    chk("s2_data",  32'(cap_data[0]), 32'h55);
    chk("s2_perr",  32'(cap_perr[0]), 32'd1);
    chk("s2_ferr",  32'(cap_ferr[0]), 32'd0);
    chk("s2_sum",   o_sum,            32'd0);

    // 3: one-cycle low glitch
    do_reset();
    ser = 1'b0;
    idle(1);
    ser = 1'b1;
    idle(60);
    chk("s3_vcyc",  32'(vcycles), 32'd0);
    chk("s3_valid", 32'(o_valid), 32'd0);
    chk("s3_sum",   o_sum,        32'd0);

    // 4: framing error into a break, then a clean 0xA3
    do_reset();
    send_frame(1'b0, 9'h03C, 8, 0, 1'b0, 1);
    idle(20);
    ser = 1'b1;
    idle(8);
    send_frame(1'b0, 9'h0A3, 8, 0, 1'b1, 1);
    idle(10);
    chk("s4_count", 32'(cap_cnt),     32'd2);
    chk("s4_data0", 32'(cap_data[0]), 32'h3C);
    chk("s4_ferr0", 32'(cap_ferr[0]), 32'd1);
    chk("s4_data1", 32'(cap_data[1]), 32'hA3);
    chk("s4_err1",  {30'd0, cap_perr[1], cap_ferr[1]}, 32'd0);
    chk("s4_sum",   o_sum,            32'hA3);

    // 5: overrun with i_ready low, back-to-back 0x11 / 0x22
    do_reset();
    rdy = 1'b0;
    send_frame(1'b0, 9'h011, 8, 0, 1'b1, 1);
    send_frame(1'b0, 9'h022, 8, 0, 1'b1, 1);
    idle(8);
    chk("s5_valid", 32'(o_valid), 32'd1);
    chk("s5_data",  32'(o_data),  32'h11);
    chk("s5_ovr",   32'(o_ovr),   32'd1);
    chk("s5_sum",   o_sum,        32'h11);
    rdy = 1'b1;
    idle(1);
    rdy = 1'b0;
    idle(1);
    chk("s5_valid_clr", 32'(o_valid),     32'd0);
    chk("s5_ovr_clr",   32'(o_ovr),       32'd0);
    chk("s5_cap",       32'(cap_data[0]), 32'h11);

    // 6: reset during data bit 4 of 0x7E, then 0x81
    do_reset();
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    ser = 1'b1;
    idle(2);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(60);
    chk("s6_abort", 32'(vcycles), 32'd0);
    send_frame(1'b0, 9'h081, 8, 0, 1'b1, 1);
    idle(10);
    chk("s6_count", 32'(cap_cnt),     32'd1);
    chk("s6_data",  32'(cap_data[0]), 32'h81);
    chk("s6_sum",   o_sum,            32'h81);

    // 7: 7 data bits, no parity, 2 stops
    do_reset();
    send_frame(1'b1, 9'h05A, 7, -1, 1'b1, 2);
    idle(10);
    chk("s7_count", 32'(cap7_cnt),  32'd1);
    chk("s7_data",  32'(cap7_data), 32'h5A);
    chk("s7_err",   32'(cap7_err),  32'd0);
    chk("s7_sum",   o_sum7,         32'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
